// File: rtl/cache_mem_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding and grant identifiers.
package aquila_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// I-cache, D-cache and memory-master signal bundle for the shared line port.
// slave = arbiter view, master = environment view.
interface cache_mem_arbiter_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHE_LINE_SIZE = 256
);
    logic                       i_strobe_i;
    logic [ADDR_WIDTH-1:0]      i_addr_i;
    logic                       i_done_o;
    logic [CACHE_LINE_SIZE-1:0] i_data_o;

    logic                       d_strobe_i;
    logic [ADDR_WIDTH-1:0]      d_addr_i;
    logic                       d_rw_i;
    logic [CACHE_LINE_SIZE-1:0] d_data_i;
    logic                       d_done_o;
    logic [CACHE_LINE_SIZE-1:0] d_data_o;

    logic                       m_strobe_o;
    logic [ADDR_WIDTH-1:0]      m_addr_o;
    logic                       m_rw_o;
    logic [CACHE_LINE_SIZE-1:0] m_data_o;
    logic                       m_done_i;
    logic [CACHE_LINE_SIZE-1:0] m_data_i;

    modport slave (
        input  i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i,
               m_done_i, m_data_i,
        output i_done_o, i_data_o, d_done_o, d_data_o,
               m_strobe_o, m_addr_o, m_rw_o, m_data_o
    );

    modport master (
        output i_strobe_i, i_addr_i, d_strobe_i, d_addr_i, d_rw_i, d_data_i,
               m_done_i, m_data_i,
        input  i_done_o, i_data_o, d_done_o, d_data_o,
               m_strobe_o, m_addr_o, m_rw_o, m_data_o
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Shares one line-wide memory master between I-cache and D-cache refill ports.
// ARB_ROUND_ROBIN_EN selects round-robin instead of fixed D-over-I priority.
module cache_mem_arbiter
    import aquila_arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHE_LINE_SIZE = 256
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cache_mem_arbiter_if.slave bus
);

    arb_state_t                 state_q;
    logic                       win_q;
    logic                       pend_i_q, pend_i_d, pend_d_q, pend_d_d;
    logic [ADDR_WIDTH-1:0]      i_addr_q, d_addr_q;
    logic                       d_rw_q;
    logic [CACHE_LINE_SIZE-1:0] d_wdata_q;

    logic                       m_strobe_q, m_rw_q, i_done_q, d_done_q;
    logic [ADDR_WIDTH-1:0]      m_addr_q;
    logic [CACHE_LINE_SIZE-1:0] m_data_q, i_rdata_q, d_rdata_q;

    logic                       busy, acc_i, acc_d, req_i, req_d, grant, win_d;
    logic [ADDR_WIDTH-1:0]      eff_i_addr, eff_d_addr;
    logic                       eff_d_rw;
    logic [CACHE_LINE_SIZE-1:0] eff_d_data;

`ifdef ARB_ROUND_ROBIN_EN
    // win_q doubles as the last-winner pointer; the other port wins a tie.
    function automatic logic pick(input logic ri, input logic rd, input logic last);
        if (ri && rd) return (last == GRANT_D) ? GRANT_I : GRANT_D;
        return rd ? GRANT_D : GRANT_I;
    endfunction
    assign win_d = pick(req_i, req_d, win_q);
`else
    function automatic logic pick(input logic rd);
        return rd ? GRANT_D : GRANT_I;
    endfunction
    assign win_d = pick(req_d);
`endif

    // A port being issued/awaited cannot take a new request; DONE can.
    assign busy  = (state_q == ISSUE) || (state_q == WAIT);
    assign acc_i = bus.i_strobe_i && !pend_i_q && !(busy && win_q == GRANT_I);
    assign acc_d = bus.d_strobe_i && !pend_d_q && !(busy && win_q == GRANT_D);
    assign req_i = pend_i_q || acc_i;
    assign req_d = pend_d_q || acc_d;
    assign grant = (state_q == IDLE) && (req_i || req_d);

    assign eff_i_addr = pend_i_q ? i_addr_q  : bus.i_addr_i;
    assign eff_d_addr = pend_d_q ? d_addr_q  : bus.d_addr_i;
    assign eff_d_rw   = pend_d_q ? d_rw_q    : bus.d_rw_i;
    assign eff_d_data = pend_d_q ? d_wdata_q : bus.d_data_i;

    assign pend_i_d = req_i && !(grant && win_d == GRANT_I);
    assign pend_d_d = req_d && !(grant && win_d == GRANT_D);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_i_q  <= 1'b0;
            pend_d_q  <= 1'b0;
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            d_rw_q    <= 1'b0;
            d_wdata_q <= '0;
        end else begin
            pend_i_q <= pend_i_d;
            pend_d_q <= pend_d_d;
            if (acc_i) i_addr_q <= bus.i_addr_i;
            if (acc_d) begin
                d_addr_q  <= bus.d_addr_i;
                d_rw_q    <= bus.d_rw_i;
                d_wdata_q <= bus.d_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            win_q      <= GRANT_D;
            m_strobe_q <= 1'b0;
            m_addr_q   <= '0;
            m_rw_q     <= 1'b0;
            m_data_q   <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            m_strobe_q <= 1'b0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            case (state_q)
                IDLE: if (grant) begin
                    win_q      <= win_d;
                    m_strobe_q <= 1'b1;
                    m_addr_q   <= (win_d == GRANT_D) ? eff_d_addr : eff_i_addr;
                    m_rw_q     <= (win_d == GRANT_D) ? eff_d_rw : 1'b0;
                    m_data_q   <= (win_d == GRANT_D) ? eff_d_data : '0;
                    state_q    <= ISSUE;
                end
                ISSUE: state_q <= WAIT;
                WAIT: if (bus.m_done_i) begin
                    if (!m_rw_q) begin
                        if (win_q == GRANT_D) d_rdata_q <= bus.m_data_i;
                        else                  i_rdata_q <= bus.m_data_i;
                    end
                    if (win_q == GRANT_D) d_done_q <= 1'b1;
                    else                  i_done_q <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_strobe_o = m_strobe_q;
    assign bus.m_addr_o   = m_addr_q;
    assign bus.m_rw_o     = m_rw_q;
    assign bus.m_data_o   = m_data_q;
    assign bus.i_done_o   = i_done_q;
    assign bus.i_data_o   = i_rdata_q;
    assign bus.d_done_o   = d_done_q;
    assign bus.d_data_o   = d_rdata_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed, table-driven bench for cache_mem_arbiter (default fixed-priority build).
module tb_cache_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_WIDTH(32), .CACHE_LINE_SIZE(256)) bus ();

    cache_mem_arbiter #(.ADDR_WIDTH(32), .CACHE_LINE_SIZE(256)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Line data is written as a repeated 16-bit (write) or 8-bit (read) pattern.
    typedef struct {
        logic        is;   logic [31:0] ia;
        logic        ds;   logic        drw; logic [31:0] da; logic [15:0] dd;
        logic        md;   logic [7:0]  mdat;
        logic        ems;  logic [31:0] ema; logic emrw; logic [15:0] emdo;
        logic        eidn; logic        eddn; logic [7:0] eidat; logic [7:0] eddat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t tbl [39];

    function automatic vec_t mk(
        input logic is, input logic [31:0] ia,
        input logic ds, input logic drw, input logic [31:0] da, input logic [15:0] dd,
        input logic md, input logic [7:0] mdat,
        input logic ems, input logic [31:0] ema, input logic emrw, input logic [15:0] emdo,
        input logic eidn, input logic eddn, input logic [7:0] eidat, input logic [7:0] eddat);
        vec_t v;
        v.is = is; v.ia = ia; v.ds = ds; v.drw = drw; v.da = da; v.dd = dd;
        v.md = md; v.mdat = mdat;
        v.ems = ems; v.ema = ema; v.emrw = emrw; v.emdo = emdo;
        v.eidn = eidn; v.eddn = eddn; v.eidat = eidat; v.eddat = eddat;
        return v;
    endfunction

    task automatic chk(input string nm, input int c, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int c);
        @(negedge clk);
        bus.i_strobe_i = v.is;  bus.i_addr_i = v.ia;
        bus.d_strobe_i = v.ds;  bus.d_rw_i   = v.drw;
        bus.d_addr_i   = v.da;  bus.d_data_i = {16{v.dd}};
        bus.m_done_i   = v.md;  bus.m_data_i = {32{v.mdat}};
        chk("m_strobe", c, 256'(bus.m_strobe_o), 256'(v.ems));
        chk("m_addr",   c, 256'(bus.m_addr_o),   256'(v.ema));
        chk("m_rw",     c, 256'(bus.m_rw_o),     256'(v.emrw));
        chk("m_data",   c, bus.m_data_o,         {16{v.emdo}});
        chk("i_done",   c, 256'(bus.i_done_o),   256'(v.eidn));
        chk("d_done",   c, 256'(bus.d_done_o),   256'(v.eddn));
        chk("i_data",   c, bus.i_data_o,         {32{v.eidat}});
        chk("d_data",   c, bus.d_data_o,         {32{v.eddat}});
    endtask

    initial begin
        // single I read
        tbl[0]  = mk(1,32'h80000040,0,0,0,0,0,0,       0,0,0,0,0,0,0,0);
        tbl[1]  = mk(0,0,0,0,0,0,0,0,                  1,32'h80000040,0,0,0,0,0,0);
        tbl[2]  = mk(0,0,0,0,0,0,0,0,                  0,32'h80000040,0,0,0,0,0,0);
        tbl[3]  = mk(0,0,0,0,0,0,0,0,                  0,32'h80000040,0,0,0,0,0,0);
        tbl[4]  = mk(0,0,0,0,0,0,1,8'hA5,              0,32'h80000040,0,0,0,0,0,0);
        tbl[5]  = mk(0,0,0,0,0,0,0,0,                  0,32'h80000040,0,0,1,0,8'hA5,0);
        tbl[6]  = mk(0,0,0,0,0,0,0,0,                  0,32'h80000040,0,0,0,0,8'hA5,0);
        // D write-back; returned memory data must not reach d_data_o
        tbl[7]  = mk(0,0,1,1,32'h80001000,16'h1234,0,0, 0,32'h80000040,0,0,0,0,8'hA5,0);
        tbl[8]  = mk(0,0,0,0,0,0,0,0,                  1,32'h80001000,1,16'h1234,0,0,8'hA5,0);
        tbl[9]  = mk(0,0,0,0,0,0,0,0,                  0,32'h80001000,1,16'h1234,0,0,8'hA5,0);
        tbl[10] = mk(0,0,0,0,0,0,1,8'h77,              0,32'h80001000,1,16'h1234,0,0,8'hA5,0);
        tbl[11] = mk(0,0,0,0,0,0,0,0,                  0,32'h80001000,1,16'h1234,0,1,8'hA5,0);
        tbl[12] = mk(0,0,0,0,0,0,1,8'hFF,              0,32'h80001000,1,16'h1234,0,0,8'hA5,0);
        tbl[13] = mk(0,0,0,0,0,0,0,0,                  0,32'h80001000,1,16'h1234,0,0,8'hA5,0);
        // simultaneous strobes: D first; a repeat I strobe while pending is dropped
        tbl[14] = mk(1,32'h80000080,1,0,32'h80002000,16'hBEEF,0,0, 0,32'h80001000,1,16'h1234,0,0,8'hA5,0);
        tbl[15] = mk(0,0,0,0,0,0,0,0,                  1,32'h80002000,0,16'hBEEF,0,0,8'hA5,0);
        tbl[16] = mk(1,32'hDEAD0000,0,0,0,0,0,0,       0,32'h80002000,0,16'hBEEF,0,0,8'hA5,0);
        tbl[17] = mk(0,0,0,0,0,0,1,8'h3C,              0,32'h80002000,0,16'hBEEF,0,0,8'hA5,0);
        tbl[18] = mk(0,0,0,0,0,0,0,0,                  0,32'h80002000,0,16'hBEEF,0,1,8'hA5,8'h3C);
        tbl[19] = mk(0,0,0,0,0,0,0,0,                  0,32'h80002000,0,16'hBEEF,0,0,8'hA5,8'h3C);
        tbl[20] = mk(0,0,0,0,0,0,0,0,                  1,32'h80000080,0,0,0,0,8'hA5,8'h3C);
        tbl[21] = mk(0,0,0,0,0,0,0,0,                  0,32'h80000080,0,0,0,0,8'hA5,8'h3C);
        tbl[22] = mk(0,0,0,0,0,0,1,8'h5A,              0,32'h80000080,0,0,0,0,8'hA5,8'h3C);
        tbl[23] = mk(0,0,0,0,0,0,0,0,                  0,32'h80000080,0,0,1,0,8'h5A,8'h3C);
        tbl[24] = mk(0,0,0,0,0,0,0,0,                  0,32'h80000080,0,0,0,0,8'h5A,8'h3C);
        // I strobe during D's WAIT keeps its original address
        tbl[25] = mk(0,0,1,0,32'h80003000,16'h0000,0,0, 0,32'h80000080,0,0,0,0,8'h5A,8'h3C);
        tbl[26] = mk(0,0,0,0,0,0,0,0,                  1,32'h80003000,0,0,0,0,8'h5A,8'h3C);
        tbl[27] = mk(1,32'h800000C0,0,0,0,0,0,0,       0,32'h80003000,0,0,0,0,8'h5A,8'h3C);
        tbl[28] = mk(0,32'h11111100,0,0,0,0,1,8'h11,   0,32'h80003000,0,0,0,0,8'h5A,8'h3C);
        tbl[29] = mk(0,0,0,0,0,0,0,0,                  0,32'h80003000,0,0,0,1,8'h5A,8'h11);
        tbl[30] = mk(0,0,0,0,0,0,0,0,                  0,32'h80003000,0,0,0,0,8'h5A,8'h11);
        tbl[31] = mk(0,0,0,0,0,0,0,0,                  1,32'h800000C0,0,0,0,0,8'h5A,8'h11);
        tbl[32] = mk(0,0,0,0,0,0,1,8'h22,              0,32'h800000C0,0,0,0,0,8'h5A,8'h11);
        // I strobe in its own DONE cycle is captured and served next
        tbl[33] = mk(1,32'h80000100,0,0,0,0,0,0,       0,32'h800000C0,0,0,1,0,8'h22,8'h11);
        tbl[34] = mk(0,0,0,0,0,0,0,0,                  0,32'h800000C0,0,0,0,0,8'h22,8'h11);
        tbl[35] = mk(0,0,0,0,0,0,0,0,                  1,32'h80000100,0,0,0,0,8'h22,8'h11);
        tbl[36] = mk(0,0,0,0,0,0,1,8'h33,              0,32'h80000100,0,0,0,0,8'h22,8'h11);
        tbl[37] = mk(0,0,0,0,0,0,0,0,                  0,32'h80000100,0,0,1,0,8'h33,8'h11);
        tbl[38] = mk(0,0,0,0,0,0,0,0,                  0,32'h80000100,0,0,0,0,8'h33,8'h11);

        bus.i_strobe_i = 0; bus.i_addr_i = '0;
        bus.d_strobe_i = 0; bus.d_rw_i = 0; bus.d_addr_i = '0; bus.d_data_i = '0;
        bus.m_done_i = 0;   bus.m_data_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 39; i++) step(tbl[i], i);

        // reset during WAIT of a D write-back, then a stray m_done_i
        step(mk(0,0,1,1,32'h80004000,16'hCAFE,0,0, 0,32'h80000100,0,0,0,0,8'h33,8'h11), 100);
        step(mk(0,0,0,0,0,0,0,0, 1,32'h80004000,1,16'hCAFE,0,0,8'h33,8'h11), 101);
        step(mk(0,0,0,0,0,0,0,0, 0,32'h80004000,1,16'hCAFE,0,0,8'h33,8'h11), 102);
        rst = 1'b1;
        step(mk(0,0,0,0,0,0,1,8'h99, 0,0,0,0,0,0,0,0), 103);
        rst = 1'b0;
        step(mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0), 104);
        step(mk(1,32'h80000200,0,0,0,0,0,0, 0,0,0,0,0,0,0,0), 105);
        step(mk(0,0,0,0,0,0,0,0, 1,32'h80000200,0,0,0,0,0,0), 106);
        step(mk(0,0,0,0,0,0,1,8'h44, 0,32'h80000200,0,0,0,0,0,0), 107);
        step(mk(0,0,0,0,0,0,0,0, 0,32'h80000200,0,0,1,0,8'h44,0), 108);
        step(mk(0,0,0,0,0,0,0,0, 0,32'h80000200,0,0,0,0,8'h44,0), 109);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
